// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC step/reverse helpers and FSM state type for the CRC stream engine
package crc_pkg;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // One serial CRC step on the low w bits of crc (w <= 32); upper bits come back zero.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b,
                                           input logic [31:0] poly, input int w);
    logic [31:0] sh;
    logic [31:0] mask;
    logic        fb;
    sh   = crc >> (w - 1);
    fb   = sh[0] ^ b;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return ((crc << 1) ^ (fb ? poly : 32'd0)) & mask;
  endfunction

  // Reverses the low w bits of v (w <= 64).
  function automatic logic [63:0] bit_reverse(input logic [63:0] v, input int w);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        r = {r[62:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_xor_tree.sv
// rtl/crc_xor_tree.sv - combinational multi-bit CRC update, MSB-first, with partial-beat bit count
module crc_xor_tree
  import crc_pkg::*;
#(
  parameter int              CRC_W  = 5,
  parameter logic [CRC_W-1:0] POLY  = 5'h05,
  parameter int              DATA_W = 4
) (
  input  logic [CRC_W-1:0]              crc_in,
  input  logic [DATA_W-1:0]             data,
  input  logic [$clog2(DATA_W+1)-1:0]   nbits,
  output logic [CRC_W-1:0]              crc_out
);

  int               n_eff;
  logic [CRC_W-1:0] acc;

  // nbits of 0 or anything above DATA_W means a full beat
  always_comb begin
    n_eff = int'(nbits);
    if (n_eff == 0 || n_eff > DATA_W) n_eff = DATA_W;
    acc = crc_in;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < n_eff) acc = CRC_W'(crc_step(32'(acc), data[DATA_W-1-i], 32'(POLY), CRC_W));
    end
  end

  assign crc_out = acc;

endmodule

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - streaming CRC generator/checker with framing, handshake and residue check
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 5,
  parameter logic [CRC_W-1:0] POLY    = 5'h05,
  parameter int               DATA_W  = 4,
  parameter logic [CRC_W-1:0] INIT    = 5'h1F,
  parameter logic [CRC_W-1:0] XOROUT  = 5'h00,
  parameter logic [CRC_W-1:0] RESIDUE = 5'h00,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_W-1:0]               s_data,
  input  logic                            s_sof,
  input  logic                            s_eof,
  input  logic [$clog2(DATA_W+1)-1:0]     s_nbits,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [CRC_W-1:0]                m_crc,
  output logic                            m_match,
  output logic [CRC_W-1:0]                crc_state,
  output logic                            sof_abort
);

  localparam int NBITS_W = $clog2(DATA_W + 1);

  state_t             state;
  logic               accept;
  logic [DATA_W-1:0]  data_in;
  logic [CRC_W-1:0]   seed;
  logic [CRC_W-1:0]   crc_next;
  logic [CRC_W-1:0]   crc_final;
  logic [NBITS_W-1:0] beat_nbits;

  // Stall only while a finished result is waiting for the consumer
  assign s_ready    = !rst && !(m_valid && !m_ready);
  assign accept     = s_valid && s_ready;
  assign data_in    = REFIN ? DATA_W'(bit_reverse(64'(s_data), DATA_W)) : s_data;
  assign seed       = (state == IDLE || s_sof) ? INIT : crc_state;
  assign beat_nbits = s_eof ? s_nbits : '0;
  assign crc_final  = (REFOUT ? CRC_W'(bit_reverse(64'(crc_next), CRC_W)) : crc_next) ^ XOROUT;

  crc_xor_tree #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .DATA_W (DATA_W)
  ) u_tree (
    .crc_in  (seed),
    .data    (data_in),
    .nbits   (beat_nbits),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      crc_state <= INIT;
      m_valid   <= 1'b0;
      m_crc     <= '0;
      m_match   <= 1'b0;
      sof_abort <= 1'b0;
    end else begin
      sof_abort <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (accept) begin
        crc_state <= crc_next;
        if (state == ACTIVE && s_sof) sof_abort <= 1'b1;
        if (s_eof) begin
          m_valid <= 1'b1;
          m_crc   <= crc_final;
          m_match <= (crc_next == RESIDUE);
          state   <= IDLE;
        end else begin
          state <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - directed and randomized checks of crc_stream_engine in three configurations
module tb_crc_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic sv_a, sr_a, sof_a, eof_a, mv_a, mr_a, mm_a, ab_a;
  logic [3:0] sd_a;
  logic [2:0] nb_a;
  logic [4:0] mc_a, cs_a;

  logic sv_b, sr_b, sof_b, eof_b, mv_b, mr_b, mm_b, ab_b;
  logic [7:0] sd_b;
  logic [3:0] nb_b;
  logic [15:0] mc_b, cs_b;

  logic sv_c, sr_c, sof_c, eof_c, mv_c, mr_c, mm_c, ab_c;
  logic [0:0] sd_c;
  logic [0:0] nb_c;
  logic [4:0] mc_c, cs_c;

  int total = 0;
  int bad = 0;

  int          cw   [3] = '{5, 16, 5};
  int          dw   [3] = '{4, 8, 1};
  int          nbw  [3] = '{3, 4, 1};
  logic [31:0] poly [3] = '{32'h05, 32'h8005, 32'h05};
  logic [31:0] init [3] = '{32'h1F, 32'hFFFF, 32'h1F};
  logic [31:0] xo   [3] = '{32'h0, 32'hFFFF, 32'h0};
  logic [31:0] res  [3] = '{32'h0, 32'h0, 32'h0};
  bit          rin  [3] = '{1'b0, 1'b1, 1'b0};
  bit          rout [3] = '{1'b0, 1'b1, 1'b0};

  crc_stream_engine dut_a (
    .clk(clk), .rst(rst), .s_valid(sv_a), .s_ready(sr_a), .s_data(sd_a), .s_sof(sof_a),
    .s_eof(eof_a), .s_nbits(nb_a), .m_valid(mv_a), .m_ready(mr_a), .m_crc(mc_a),
    .m_match(mm_a), .crc_state(cs_a), .sof_abort(ab_a)
  );

  crc_stream_engine #(
    .CRC_W(16), .POLY(16'h8005), .DATA_W(8), .INIT(16'hFFFF), .XOROUT(16'hFFFF),
    .RESIDUE(16'h0000), .REFIN(1'b1), .REFOUT(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(sr_b), .s_data(sd_b), .s_sof(sof_b),
    .s_eof(eof_b), .s_nbits(nb_b), .m_valid(mv_b), .m_ready(mr_b), .m_crc(mc_b),
    .m_match(mm_b), .crc_state(cs_b), .sof_abort(ab_b)
  );

  crc_stream_engine #(.DATA_W(1)) dut_c (
    .clk(clk), .rst(rst), .s_valid(sv_c), .s_ready(sr_c), .s_data(sd_c), .s_sof(sof_c),
    .s_eof(eof_c), .s_nbits(nb_c), .m_valid(mv_c), .m_ready(mr_c), .m_crc(mc_c),
    .m_match(mm_c), .crc_state(cs_c), .sof_abort(ab_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int c, input bit v, input logic [7:0] d, input bit sof,
                       input bit eof, input logic [3:0] nb);
    case (c)
      0: begin sv_a = v; sd_a = d[3:0]; sof_a = sof; eof_a = eof; nb_a = nb[2:0]; end
      1: begin sv_b = v; sd_b = d;      sof_b = sof; eof_b = eof; nb_b = nb;      end
      default: begin sv_c = v; sd_c = d[0:0]; sof_c = sof; eof_c = eof; nb_c = nb[0:0]; end
    endcase
  endtask

  task automatic sample(input int c, output logic mv, output logic sr,
                        output logic [31:0] crc, output logic mm);
    case (c)
      0: begin mv = mv_a; sr = sr_a; crc = 32'(mc_a); mm = mm_a; end
      1: begin mv = mv_b; sr = sr_b; crc = 32'(mc_b); mm = mm_b; end
      default: begin mv = mv_c; sr = sr_c; crc = 32'(mc_c); mm = mm_c; end
    endcase
  endtask

  function automatic logic [31:0] rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = v[i];
    return r;
  endfunction

  // Whole-frame reference: flatten the frame to a message bit list, then divide bit by bit.
  function automatic void model(input int c, input logic [7:0] beats[$], input int nlast,
                                output logic [31:0] raw, output logic [31:0] fin);
    bit          msg[$];
    logic [31:0] d, r, mask;
    int          n, w;
    bit          top;
    w = cw[c];
    for (int k = 0; k < beats.size(); k++) begin
      d = 32'(beats[k]);
      if (rin[c]) d = rev(d, dw[c]);
      n = dw[c];
      if (k == beats.size() - 1 && nlast != 0 && nlast <= dw[c]) n = nlast;
      for (int j = 0; j < n; j++) msg.push_back(d[dw[c]-1-j]);
    end
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    r = init[c];
    foreach (msg[i]) begin
      top = r[w-1];
      r = ((r << 1) ^ ((top ^ msg[i]) ? poly[c] : 32'd0)) & mask;
    end
    raw = r;
    fin = (rout[c] ? rev(r, w) : r) ^ xo[c];
  endfunction

  initial begin
    logic        mv, sr, mm;
    logic [31:0] crc, raw, fin;
    logic [7:0]  beats[$];
    int          len, nb;
    bit          sof;

    for (int c = 0; c < 3; c++) drive(c, 0, 8'h0, 0, 0, 4'h0);
    mr_a = 1'b1; mr_b = 1'b1; mr_c = 1'b1;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", 32'(sr_a), 32'd0);
    chk("rst_m_valid", 32'(mv_a), 32'd0);
    chk("rst_m_crc", 32'(mc_a), 32'd0);
    chk("rst_m_match", 32'(mm_a), 32'd0);
    chk("rst_sof_abort", 32'(ab_a), 32'd0);
    chk("rst_crc_state", 32'(cs_a), 32'h1F);
    rst = 1'b0;

    drive(0, 1, 8'h0, 1, 1, 4'h0);
    tick();
    drive(0, 0, 8'h0, 0, 0, 4'h0);
    chk("t1_valid", 32'(mv_a), 32'd1);
    chk("t1_crc", 32'(mc_a), 32'h06);
    chk("t1_match", 32'(mm_a), 32'd0);
    chk("t1_state", 32'(cs_a), 32'h06);
    tick();
    chk("t1_consumed", 32'(mv_a), 32'd0);
    chk("t1_state_hold", 32'(cs_a), 32'h06);

    drive(0, 1, 8'h0, 1, 0, 4'h0);
    tick();
    drive(0, 1, 8'h3, 0, 0, 4'h0);
    tick();
    drive(0, 1, 8'h0, 0, 1, 4'h1);
    tick();
    drive(0, 0, 8'h0, 0, 0, 4'h0);
    chk("t2_valid", 32'(mv_a), 32'd1);
    chk("t2_match", 32'(mm_a), 32'd1);
    chk("t2_crc", 32'(mc_a), 32'h00);
    tick();

    mr_a = 1'b0;
    drive(0, 1, 8'hF, 1, 1, 4'h0);
    tick();
    drive(0, 1, 8'h0, 1, 1, 4'h0);
    chk("t3_pending_crc", 32'(mc_a), 32'h10);
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall_ready", 32'(sr_a), 32'd0);
      chk("t3_stall_valid", 32'(mv_a), 32'd1);
      chk("t3_stall_crc", 32'(mc_a), 32'h10);
      tick();
    end
    mr_a = 1'b1;
    tick();
    drive(0, 0, 8'h0, 0, 0, 4'h0);
    chk("t3_back_to_back_valid", 32'(mv_a), 32'd1);
    chk("t3_back_to_back_crc", 32'(mc_a), 32'h06);
    tick();
    chk("t3_drained", 32'(mv_a), 32'd0);

    drive(0, 1, 8'hF, 1, 0, 4'h0);
    tick();
    chk("t4_no_abort_from_idle", 32'(ab_a), 32'd0);
    drive(0, 1, 8'h0, 1, 1, 4'h0);
    tick();
    drive(0, 0, 8'h0, 0, 0, 4'h0);
    chk("t4_abort", 32'(ab_a), 32'd1);
    chk("t4_valid", 32'(mv_a), 32'd1);
    chk("t4_crc", 32'(mc_a), 32'h06);
    tick();
    chk("t4_abort_once", 32'(ab_a), 32'd0);
    chk("t4_single_result", 32'(mv_a), 32'd0);

    drive(0, 1, 8'hF, 1, 0, 4'h0);
    tick();
    drive(0, 1, 8'h3, 0, 0, 4'h0);
    tick();
    drive(0, 0, 8'h0, 0, 0, 4'h0);
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(mv_a), 32'd0);
    chk("t5_rst_state", 32'(cs_a), 32'h1F);
    rst = 1'b0;
    tick();
    chk("t5_no_stale", 32'(mv_a), 32'd0);
    drive(0, 1, 8'h0, 1, 1, 4'h0);
    tick();
    drive(0, 0, 8'h0, 0, 0, 4'h0);
    chk("t5_valid", 32'(mv_a), 32'd1);
    chk("t5_crc", 32'(mc_a), 32'h06);
    tick();

    // CRC-16/USB check string "123456789"
    for (int k = 0; k < 9; k++) begin
      drive(1, 1, 8'(8'h31 + k), k == 0, k == 8, 4'h0);
      tick();
    end
    drive(1, 0, 8'h0, 0, 0, 4'h0);
    chk("usb16_check_value", 32'(mc_b), 32'hB4C8);
    tick();

    for (int c = 0; c < 3; c++) begin
      for (int f = 0; f < 25; f++) begin
        len = $urandom_range(1, 5);
        nb = $urandom_range(0, (1 << nbw[c]) - 1);
        beats.delete();
        for (int k = 0; k < len; k++) beats.push_back(8'($urandom & ((1 << dw[c]) - 1)));
        model(c, beats, nb, raw, fin);
        for (int k = 0; k < len; k++) begin
          sof = (k == 0) ? bit'($urandom_range(0, 1)) : 1'b0;
          drive(c, 1, beats[k], sof, k == len - 1,
                (k == len - 1) ? 4'(nb) : 4'($urandom_range(0, 15)));
          sample(c, mv, sr, crc, mm);
          chk("rnd_ready", 32'(sr), 32'd1);
          tick();
        end
        drive(c, 0, 8'h0, 0, 0, 4'h0);
        sample(c, mv, sr, crc, mm);
        chk("rnd_valid", 32'(mv), 32'd1);
        chk("rnd_crc", crc, fin);
        chk("rnd_match", 32'(mm), 32'(raw == res[c]));
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
